// File: rtl/conv_sched_pkg.sv
// Shared types and default widths for the convolution job sequencer.
package conv_sched_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_OFM_W  = 13;
  localparam int unsigned DEF_TMO_W  = 12;

  // Job sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_RD_W   = 3'd2,
    ST_RD_IFM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Tag carried alongside each read to pick the core strobe it feeds.
  typedef enum logic {
    TAG_W   = 1'b0,
    TAG_IFM = 1'b1
  } tag_e;

endpackage

// File: rtl/conv_sched_rdgen.sv
// Read address generator plus the one-cycle tag/valid pipeline that turns
// SRAM read data into weight or IFM strobes for the core.
module conv_sched_rdgen
  import conv_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  tag_e              tag_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] words_i,
  output logic              last_o,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              weight_valid_o,
  output logic              in_valid_o,
  output logic [DATA_W-1:0] weight_o,
  output logic [DATA_W-1:0] ifm_o
);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              vld_q;
  tag_e              tag_q;

  // Offset within the current phase; returns to zero on the last read so the
  // following phase starts at its own base with no bubble.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idx_d  = '0;
    last_o = issue_i && (idx_q == words_i - 1'b1);
    if (issue_i && !last_o) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Phase offset register and the read-to-data tag/valid pipeline.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      idx_q <= '0;
      vld_q <= 1'b0;
      tag_q <= TAG_W;
    end else begin
      idx_q <= idx_d;
      vld_q <= issue_i;
      tag_q <= tag_i;
    end
  end

  assign mem_ren_o      = issue_i;
  assign mem_raddr_o    = issue_i ? base_i + idx_q : '0;
  assign weight_valid_o = vld_q && (tag_q == TAG_W);
  assign in_valid_o     = vld_q && (tag_q == TAG_IFM);
  // The SRAM returns data one cycle after the read, aligned with the strobe.
  assign weight_o       = weight_valid_o ? mem_rdata_i : '0;
  assign ifm_o          = in_valid_o ? mem_rdata_i : '0;

endmodule

// File: rtl/conv_sched.sv
// Job-level sequencer for one Convolution core: clears the core, streams
// weights then IFM from the input SRAM, and collects results into the
// output SRAM, finishing on result count or a drain timeout.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OFM_W  = DEF_OFM_W,
  parameter int unsigned TMO_W  = DEF_TMO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_ofm_base,
  input  logic [ADDR_W-1:0] cfg_w_words,
  input  logic [ADDR_W-1:0] cfg_ifm_words,
  input  logic [ADDR_W-1:0] cfg_ofm_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              conv_rst_n,
  output logic              conv_weight_valid,
  output logic              conv_in_valid,
  output logic [DATA_W-1:0] conv_weight,
  output logic [DATA_W-1:0] conv_ifm,
  input  logic              conv_out_valid,
  input  logic [OFM_W-1:0]  conv_ofm,
  output logic              ofm_we,
  output logic [ADDR_W-1:0] ofm_waddr,
  output logic [OFM_W-1:0]  ofm_wdata
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_e            state_q, state_d;
  logic              clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] w_base_q, ifm_base_q, ofm_base_q;
  logic [ADDR_W-1:0] w_words_q, ifm_words_q, ofm_count_q;
  logic [ADDR_W-1:0] res_cnt_q, res_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              conv_rst_n_q;

  logic              accept, capture, cnt_hit, tmo_hit;
  logic              rd_issue, rd_last;
  tag_e              rd_tag;
  logic [ADDR_W-1:0] rd_base, rd_words;

  // Read phase selection, result capture and drain timeout arithmetic.
  always_comb begin
    accept   = (state_q == ST_IDLE) && start;
    capture  = state_q inside {ST_RD_W, ST_RD_IFM, ST_DRAIN};
    rd_issue = state_q inside {ST_RD_W, ST_RD_IFM};
    rd_tag   = (state_q == ST_RD_IFM) ? TAG_IFM : TAG_W;
    rd_base  = (state_q == ST_RD_IFM) ? ifm_base_q : w_base_q;
    rd_words = (state_q == ST_RD_IFM) ? ifm_words_q : w_words_q;

    // Results past the configured count are dropped, so the index never overruns.
    ofm_we    = capture && conv_out_valid && (res_cnt_q < ofm_count_q);
    res_cnt_d = res_cnt_q;
    if (accept) begin
      res_cnt_d = '0;
    end else if (ofm_we) begin
      res_cnt_d = res_cnt_q + 1'b1;
    end

    // Idle-cycle counter: only meaningful in DRAIN, restarted by any result.
    tmo_d = '0;
    if ((state_q == ST_DRAIN) && !conv_out_valid) begin
      tmo_d = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + 1'b1;
    end

    cnt_hit = (res_cnt_d == ofm_count_q);
    tmo_hit = (tmo_d == TMO_MAX);
  end

  // Next-state logic; zero-length phases are skipped.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = 1'b0;
    err_d     = err_q;
    if (accept) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLR;
      end
      ST_CLR: begin
        clr_cnt_d = ~clr_cnt_q;
        if (clr_cnt_q) begin
          if (w_words_q != '0)        state_d = ST_RD_W;
          else if (ifm_words_q != '0) state_d = ST_RD_IFM;
          else                        state_d = ST_DRAIN;
        end
      end
      ST_RD_W: begin
        if (rd_last) state_d = (ifm_words_q != '0) ? ST_RD_IFM : ST_DRAIN;
      end
      ST_RD_IFM: begin
        if (rd_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_hit) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, frozen job configuration and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= 1'b0;
      w_base_q     <= '0;
      ifm_base_q   <= '0;
      ofm_base_q   <= '0;
      w_words_q    <= '0;
      ifm_words_q  <= '0;
      ofm_count_q  <= '0;
      res_cnt_q    <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      conv_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      res_cnt_q    <= res_cnt_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      conv_rst_n_q <= (state_d != ST_CLR);
      if (accept) begin
        w_base_q    <= cfg_w_base;
        ifm_base_q  <= cfg_ifm_base;
        ofm_base_q  <= cfg_ofm_base;
        w_words_q   <= cfg_w_words;
        ifm_words_q <= cfg_ifm_words;
        ofm_count_q <= cfg_ofm_count;
      end
    end
  end

  conv_sched_rdgen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rdgen (
    .clk           (clk),
    .rst           (rst),
    .issue_i       (rd_issue),
    .tag_i         (rd_tag),
    .base_i        (rd_base),
    .words_i       (rd_words),
    .last_o        (rd_last),
    .mem_ren_o     (mem_ren),
    .mem_raddr_o   (mem_raddr),
    .mem_rdata_i   (mem_rdata),
    .weight_valid_o(conv_weight_valid),
    .in_valid_o    (conv_in_valid),
    .weight_o      (conv_weight),
    .ifm_o         (conv_ifm)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign conv_rst_n = conv_rst_n_q;
  assign ofm_waddr  = ofm_base_q + res_cnt_q;
  assign ofm_wdata  = conv_ofm;

endmodule
